// File: rtl/rx_controller.sv
// rx_controller: UART receive sequencer. Synchronises rx, validates the start
// bit, times mid-bit sampling and drives the rx shift register controls.
// Optional feature: define RX_PARITY_CHECK_EN to enable even-parity checking.
module rx_controller #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FRAME_BITS = 11
) (
  input  logic clk,
  input  logic preset,
  input  logic rx,
  output logic shift,
  output logic done,
  output logic sr_preset,
  output logic busy,
  output logic frame_err,
  output logic parity_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] HALF_LIMIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LIMIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] STOP_IDX   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

  state_t           state_q, state_n;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_n;
  logic             stop_q, stop_n;
  logic             shift_n, done_n, busy_n, sr_preset_n, frame_err_n;

  // Two-flop synchroniser for the asynchronous rx line
  always_ff @(posedge clk or posedge preset) begin
    if (preset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  // Next-state and output decode: start validation, mid-bit sampling, frame close
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    bitcnt_n    = bitcnt_q;
    stop_n      = stop_q;
    shift_n     = 1'b0;
    done_n      = 1'b0;
    busy_n      = busy;
    sr_preset_n = 1'b1;
    frame_err_n = frame_err;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF_LIMIT) begin
          cnt_n = '0;
          if (!rx_s) begin
            shift_n  = 1'b1;
            bitcnt_n = BIT_W'(1);
            state_n  = DATA;
          end else begin
            // start bit vanished before mid-bit: treat as a glitch
            sr_preset_n = 1'b0;
            busy_n      = 1'b0;
            state_n     = IDLE;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LIMIT) begin
          cnt_n    = '0;
          shift_n  = 1'b1;
          bitcnt_n = bitcnt_q + 1'b1;
          if (bitcnt_q == STOP_IDX) begin
            stop_n  = rx_s;
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_n      = 1'b1;
        busy_n      = 1'b0;
        frame_err_n = ~stop_q;
        bitcnt_n    = '0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      stop_q    <= 1'b0;
      shift     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      sr_preset <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      bitcnt_q  <= bitcnt_n;
      stop_q    <= stop_n;
      shift     <= shift_n;
      done      <= done_n;
      busy      <= busy_n;
      sr_preset <= sr_preset_n;
      frame_err <= frame_err_n;
    end
  end

`ifdef RX_PARITY_CHECK_EN
  localparam logic [BIT_W-1:0] PAR_IDX = BIT_W'(FRAME_BITS - 2);

  logic par_q, par_n, parity_err_n;

  // Even parity over the data samples and the parity sample, cleared while idle
  always_comb begin
    par_n        = par_q;
    parity_err_n = parity_err;
    if (state_q == IDLE) begin
      par_n = 1'b0;
    end else if (state_q == DATA && cnt_q == FULL_LIMIT && bitcnt_q <= PAR_IDX) begin
      par_n = par_q ^ rx_s;
    end
    if (state_q == DONE) parity_err_n = par_q;
  end

  // Parity accumulator and registered parity flag
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_q      <= par_n;
      parity_err <= parity_err_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
